wg_slot_arbiter: RTL and testbench
==================================

Name: wg_slot_arbiter

Overview:
Parametrised request arbiter for the workgroup's shared downstream port. It serves NCPU CPU slots plus one ACP slot at index NCPU. It selects one requester, forwards a single non-split transaction to the master port, and routes the response back to the owner. It supports round-robin mode and an ACP-priority mode with a starvation guard, and sits between the per-slot bridges and the L2/bus interface.

Parameters:
NCPU, 4, number of CPU slots; NSLOT = NCPU+1; ACP slot index = NCPU
abits, 48, request address width
dbits, 64, data width
ACP_PRIORITY, 0, 0 = round-robin over all slots; 1 = ACP fixed priority with starvation guard
STARVE_LIMIT, 8, consecutive ACP grants that may be taken while any CPU request is pending (1..255)

Ports:
i_clk  in  1  clock, rising edge
i_nrst  in  1  asynchronous active-low reset
i_req_valid  in  NSLOT  per-slot request valid
o_req_ready  out  NSLOT  per-slot accept, one-hot or zero
i_req_write  in  NSLOT  per-slot write flag
i_req_addr  in  NSLOT*abits  per-slot address; slot k occupies bits [k*abits +: abits]
i_req_wdata  in  NSLOT*dbits  per-slot write data
o_resp_valid  out  NSLOT  per-slot response strobe, one-hot or zero
o_resp_rdata  out  dbits  response data, shared by all slots
o_resp_err  out  1  response error
o_mst_req_valid  out  1  master request valid
i_mst_req_ready  in  1  master accept
o_mst_req_write  out  1  latched write flag
o_mst_req_addr  out  abits  latched address
o_mst_req_wdata  out  dbits  latched write data
i_mst_resp_valid  in  1  master response valid
i_mst_resp_rdata  in  dbits  master response data
i_mst_resp_err  in  1  master response error
o_owner  out  $clog2(NSLOT)  index of the current owner; valid while o_busy = 1
o_busy  out  1  state is not IDLE

Behaviour:
- Reset (asynchronous, i_nrst = 0): state = IDLE; rr_ptr = 0; starve_cnt = 0; owner = 0; latched write/addr/wdata = 0.
- Reset values of outputs: all outputs 0.
- A reset during REQ or RESP drops the outstanding transaction; no response is generated.
- FSM IDLE:
  - Winner is computed combinationally from i_req_valid.
  - If any request is valid, assert o_req_ready[winner] in the same cycle.
  - Latch write, addr and wdata of the winner; owner <= winner; go to REQ.
  - Only one slot is accepted per grant.
- FSM REQ:
  - o_mst_req_valid = 1 from the registered copy, so master valid appears 1 cycle after the slot handshake.
  - Latched fields stay stable until i_mst_req_ready = 1, then go to RESP.
- FSM RESP:
  - When i_mst_resp_valid = 1, o_resp_valid[owner] = 1 combinationally in the same cycle.
  - o_resp_rdata and o_resp_err are driven straight from the master response.
  - Next state is IDLE.
  - A new grant is possible in the cycle after the response, so back-to-back throughput is 1 transaction per 3 cycles minimum.
- Round-robin (ACP_PRIORITY = 0):
  - Winner is the first valid slot at or after rr_ptr, searching upward with wrap from NSLOT-1 to 0.
  - On a grant, rr_ptr <= winner+1, or 0 if winner = NSLOT-1.
- ACP priority (ACP_PRIORITY = 1):
  - If the ACP slot is valid and (no CPU slot is valid or starve_cnt < STARVE_LIMIT), the ACP slot wins.
  - Otherwise the winner is the round-robin pick among CPU slots 0..NCPU-1; rr_ptr is used the same way and never points at the ACP slot.
  - starve_cnt increments on an ACP grant while any CPU slot is valid, and saturates at STARVE_LIMIT.
  - starve_cnt clears on any CPU grant, and on an ACP grant with no CPU pending.
- Requests arriving while the state is not IDLE see o_req_ready = 0; the requester must hold valid.
- The block raises no error itself; the error bit is propagated unchanged.

Decomposition:
- Shared package workgroup_pkg:
  - ACP_SLOT_IDX (= CFG_CPU_MAX) and WG_SLOT_TOTAL = CFG_CPU_MAX+1.
  - Enum typedef wg_arb_state_type {IDLE, REQ, RESP}.
  - Packed struct wg_arb_req_type {write, addr, wdata} for the latched request.
- Sub-module wg_rr_picker:
  - Parametrised by width N.
  - Inputs: request mask and pointer. Outputs: winner index and any flag.
  - Instantiated once over all slots in mode 0, and once over the CPU-only mask in mode 1.

Test Plan:
- Reset and single request: NCPU = 4, mode 0. Release i_nrst; slot 2 reads addr 0x1000.
  - o_req_ready = 5'b00100 at cycle 0; mst valid with addr 0x1000 at cycle 1.
  - Master ready at cycle 1; resp rdata 0xDEAD at cycle 3 → o_resp_valid = 5'b00100 with rdata 0xDEAD.
- Round-robin fairness: all 5 slots held valid, master always ready, resp 1 cycle later.
  - Grant order is 0,1,2,3,4,0.
  - After slot 4 is granted, rr_ptr = 0.
- ACP priority with starvation guard: mode 1, STARVE_LIMIT = 2; ACP and slot 1 held valid.
  - Grant order is ACP, ACP, 1, ACP, ACP, 1.
- Master backpressure: i_mst_req_ready held at 0 for 10 cycles.
  - addr, wdata and write stay stable; o_req_ready stays 0 for all slots even while a new request is valid.
- Error propagation: i_mst_resp_err = 1 on a slot-3 write.
  - o_resp_valid[3] = 1 with o_resp_err = 1; the next grant proceeds normally.
- Reset mid-operation: assert i_nrst = 0 while in RESP.
  - All outputs go to 0 immediately; a late i_mst_resp_valid after reset produces no o_resp_valid.

Source files
------------

// File: rtl/workgroup_pkg.sv
// Shared types and constants for the workgroup slot arbiter.
//   CFG_CPU_MAX   : default number of CPU slots
//   ACP_SLOT_IDX  : slot index of the ACP port (after the CPU slots)
//   WG_SLOT_TOTAL : CPU slots plus the ACP slot
//   CFG_ADDR_W / CFG_DATA_W : maximum address/data widths carried by the latched request
package workgroup_pkg;

   localparam int unsigned CFG_CPU_MAX   = 4;
   localparam int unsigned ACP_SLOT_IDX  = CFG_CPU_MAX;
   localparam int unsigned WG_SLOT_TOTAL = CFG_CPU_MAX + 1;
   localparam int unsigned CFG_ADDR_W    = 48;
   localparam int unsigned CFG_DATA_W    = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } wg_arb_state_type;

   // Request captured at grant time and replayed on the master port
   typedef struct packed {
      logic                  write;
      logic [CFG_ADDR_W-1:0] addr;
      logic [CFG_DATA_W-1:0] wdata;
   } wg_arb_req_type;

endpackage

// File: rtl/wg_rr_picker.sv
// Round-robin picker: returns the first set bit of req_i at or after ptr_i,
// searching upward and wrapping from N-1 to 0. Purely combinational.
//   req_i     : request mask
//   ptr_i     : search start index (must be < N)
//   win_c_o   : winning index (0 when nothing requested)
//   any_c_o   : at least one request bit set
module wg_rr_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] win_c_o,
   output logic          any_c_o
);

   int unsigned   pos;
   logic [IW-1:0] sel;

   // Scan offsets from farthest to nearest so the nearest hit is written last
   always_comb begin
      win_c_o = '0;
      any_c_o = 1'b0;
      pos     = 0;
      sel     = '0;
      for (int unsigned j = 0; j < N; j++) begin
         pos = 32'(ptr_i) + (N - 1 - j);
         if (pos >= N) pos = pos - N;
         sel = IW'(pos);
         if (req_i[sel]) begin
            win_c_o = sel;
            any_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wg_slot_arbiter.sv
// Arbiter for the workgroup's shared downstream port: NCPU CPU slots plus one
// ACP slot (index NCPU). One non-split transaction at a time: grant in IDLE,
// present the latched request in REQ, route the response back in RESP.
//   i_req_*      : per-slot request inputs, o_req_ready one-hot accept
//   o_resp_*     : response strobe to the owner, shared data/error
//   o_mst_req_*  : registered request toward the master port
//   i_mst_*      : master handshake and response
//   o_owner/o_busy : current owner and non-IDLE indication
module wg_slot_arbiter
   import workgroup_pkg::*;
#(
   parameter int unsigned NCPU         = 4,
   parameter int unsigned abits        = 48,
   parameter int unsigned dbits        = 64,
   parameter int unsigned ACP_PRIORITY = 0,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                            i_clk,
   input  logic                            i_nrst,
   input  logic [NCPU:0]                   i_req_valid,
   output logic [NCPU:0]                   o_req_ready,
   input  logic [NCPU:0]                   i_req_write,
   input  logic [(NCPU+1)*abits-1:0]       i_req_addr,
   input  logic [(NCPU+1)*dbits-1:0]       i_req_wdata,
   output logic [NCPU:0]                   o_resp_valid,
   output logic [dbits-1:0]                o_resp_rdata,
   output logic                            o_resp_err,
   output logic                            o_mst_req_valid,
   input  logic                            i_mst_req_ready,
   output logic                            o_mst_req_write,
   output logic [abits-1:0]                o_mst_req_addr,
   output logic [dbits-1:0]                o_mst_req_wdata,
   input  logic                            i_mst_resp_valid,
   input  logic [dbits-1:0]                i_mst_resp_rdata,
   input  logic                            i_mst_resp_err,
   output logic [$clog2(NCPU+1)-1:0]       o_owner,
   output logic                            o_busy
);

   localparam int unsigned NSLOT = NCPU + 1;
   localparam int unsigned SW    = $clog2(NSLOT);
   localparam int unsigned CW    = (NCPU > 1) ? $clog2(NCPU) : 1;
   localparam int unsigned STW   = 8;

   wg_arb_state_type state_q, state_d;
   logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [STW-1:0]   starve_cnt_q, starve_cnt_d;
   logic [SW-1:0]    owner_q, owner_d;
   wg_arb_req_type   req_q, req_d;

   logic [SW-1:0]    winner;
   logic             any_req;
   logic             cpu_pend;
   logic [NSLOT-1:0] req_ready_c;
   logic [NSLOT-1:0] resp_valid_c;
   logic             resp_fire;

   assign cpu_pend = |i_req_valid[NCPU-1:0];

   // Winner selection: plain round-robin, or ACP-first bounded by the starvation guard
   if (ACP_PRIORITY == 0) begin : g_rr
      wg_rr_picker #(.N(NSLOT)) u_pick (
         .req_i   (i_req_valid),
         .ptr_i   (rr_ptr_q),
         .win_c_o (winner),
         .any_c_o (any_req)
      );
   end else begin : g_acp
      logic [CW-1:0] cpu_win;
      logic          cpu_any;
      logic          acp_win;

      wg_rr_picker #(.N(NCPU)) u_pick (
         .req_i   (i_req_valid[NCPU-1:0]),
         .ptr_i   (CW'(rr_ptr_q)),
         .win_c_o (cpu_win),
         .any_c_o (cpu_any)
      );

      assign acp_win = i_req_valid[NCPU] &
                       (!cpu_any || (starve_cnt_q < STW'(STARVE_LIMIT)));
      assign winner  = acp_win ? SW'(NCPU) : SW'(cpu_win);
      assign any_req = i_req_valid[NCPU] | cpu_any;
   end

   // State register
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         starve_cnt_q <= '0;
         owner_q      <= '0;
         req_q        <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
         req_q        <= req_d;
      end
   end

   // Next-state and slot-side handshakes
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      starve_cnt_d = starve_cnt_q;
      owner_d      = owner_q;
      req_d        = req_q;
      req_ready_c  = '0;
      resp_valid_c = '0;

      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               req_ready_c[winner] = 1'b1;
               owner_d             = winner;
               for (int unsigned k = 0; k < NSLOT; k++) begin
                  if (winner == SW'(k)) begin
                     req_d.write = i_req_write[k];
                     req_d.addr  = CFG_ADDR_W'(i_req_addr[k*abits +: abits]);
                     req_d.wdata = CFG_DATA_W'(i_req_wdata[k*dbits +: dbits]);
                  end
               end
               // In ACP mode the pointer tracks CPU slots only, so ACP grants leave it alone
               if (ACP_PRIORITY == 0) begin
                  rr_ptr_d = (winner == SW'(NSLOT - 1)) ? '0 : winner + SW'(1);
               end else if (winner != SW'(NCPU)) begin
                  rr_ptr_d = (winner == SW'(NCPU - 1)) ? '0 : winner + SW'(1);
               end
               if ((ACP_PRIORITY != 0) && (winner == SW'(NCPU)) && cpu_pend) begin
                  starve_cnt_d = (starve_cnt_q < STW'(STARVE_LIMIT)) ?
                                 starve_cnt_q + STW'(1) : starve_cnt_q;
               end else begin
                  starve_cnt_d = '0;
               end
               state_d = REQ;
            end
         end
         REQ: begin
            if (i_mst_req_ready) state_d = RESP;
         end
         RESP: begin
            if (i_mst_resp_valid) begin
               resp_valid_c[owner_q] = 1'b1;
               state_d               = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Response data is only passed through while a response is actually delivered
   assign resp_fire       = (state_q == RESP) && i_mst_resp_valid;

   assign o_req_ready     = req_ready_c;
   assign o_resp_valid    = resp_valid_c;
   assign o_resp_rdata    = resp_fire ? i_mst_resp_rdata : '0;
   assign o_resp_err      = resp_fire & i_mst_resp_err;
   assign o_mst_req_valid = (state_q == REQ);
   assign o_mst_req_write = req_q.write;
   assign o_mst_req_addr  = req_q.addr[abits-1:0];
   assign o_mst_req_wdata = req_q.wdata[dbits-1:0];
   assign o_owner         = owner_q;
   assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_wg_slot_arbiter.sv
// Directed bench for wg_slot_arbiter: one round-robin instance and one
// ACP-priority instance (STARVE_LIMIT = 2) driven by the same stimulus.
module tb_wg_slot_arbiter;

   localparam int unsigned NSLOT = 5;
   localparam int unsigned AW    = 48;
   localparam int unsigned DW    = 64;
   localparam int unsigned OW    = 3;

   logic                  clk;
   logic                  rst_n;
   logic [NSLOT-1:0]      req_valid;
   logic [NSLOT-1:0]      req_write;
   logic [NSLOT*AW-1:0]   req_addr;
   logic [NSLOT*DW-1:0]   req_wdata;
   logic                  mst_req_ready;
   logic                  mst_resp_valid;
   logic [DW-1:0]         mst_resp_rdata;
   logic                  mst_resp_err;

   logic [NSLOT-1:0]      d0_req_ready, d1_req_ready;
   logic [NSLOT-1:0]      d0_resp_valid, d1_resp_valid;
   logic [DW-1:0]         d0_resp_rdata, d1_resp_rdata;
   logic                  d0_resp_err, d1_resp_err;
   logic                  d0_mst_valid, d1_mst_valid;
   logic                  d0_mst_write, d1_mst_write;
   logic [AW-1:0]         d0_mst_addr, d1_mst_addr;
   logic [DW-1:0]         d0_mst_wdata, d1_mst_wdata;
   logic [OW-1:0]         d0_owner, d1_owner;
   logic                  d0_busy, d1_busy;

   int unsigned n_cmp;
   int unsigned n_mis;
   logic [NSLOT-1:0] g0_q[$];
   logic [NSLOT-1:0] g1_q[$];

   wg_slot_arbiter #(.NCPU(4), .abits(AW), .dbits(DW), .ACP_PRIORITY(0), .STARVE_LIMIT(8)) u_dut0 (
      .i_clk(clk), .i_nrst(rst_n),
      .i_req_valid(req_valid), .o_req_ready(d0_req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_resp_valid(d0_resp_valid), .o_resp_rdata(d0_resp_rdata), .o_resp_err(d0_resp_err),
      .o_mst_req_valid(d0_mst_valid), .i_mst_req_ready(mst_req_ready),
      .o_mst_req_write(d0_mst_write), .o_mst_req_addr(d0_mst_addr), .o_mst_req_wdata(d0_mst_wdata),
      .i_mst_resp_valid(mst_resp_valid), .i_mst_resp_rdata(mst_resp_rdata), .i_mst_resp_err(mst_resp_err),
      .o_owner(d0_owner), .o_busy(d0_busy)
   );

   wg_slot_arbiter #(.NCPU(4), .abits(AW), .dbits(DW), .ACP_PRIORITY(1), .STARVE_LIMIT(2)) u_dut1 (
      .i_clk(clk), .i_nrst(rst_n),
      .i_req_valid(req_valid), .o_req_ready(d1_req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_resp_valid(d1_resp_valid), .o_resp_rdata(d1_resp_rdata), .o_resp_err(d1_resp_err),
      .o_mst_req_valid(d1_mst_valid), .i_mst_req_ready(mst_req_ready),
      .o_mst_req_write(d1_mst_write), .o_mst_req_addr(d1_mst_addr), .o_mst_req_wdata(d1_mst_wdata),
      .i_mst_resp_valid(mst_resp_valid), .i_mst_resp_rdata(mst_resp_rdata), .i_mst_resp_err(mst_resp_err),
      .o_owner(d1_owner), .o_busy(d1_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid      = '0;
      req_write      = '0;
      req_addr       = '0;
      req_wdata      = '0;
      mst_req_ready  = 1'b0;
      mst_resp_valid = 1'b0;
      mst_resp_rdata = '0;
      mst_resp_err   = 1'b0;
   endtask

   // Leaves the bench just after a rising edge with reset released
   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Record the first n grants of each instance, bounded by a cycle budget
   task automatic collect_grants(input int n);
      g0_q.delete();
      g1_q.delete();
      for (int c = 0; c < 60 && (g0_q.size() < n || g1_q.size() < n); c++) begin
         #1;
         if (d0_req_ready != '0 && g0_q.size() < n) g0_q.push_back(d0_req_ready);
         if (d1_req_ready != '0 && g1_q.size() < n) g1_q.push_back(d1_req_ready);
         tick();
      end
   endtask

   task automatic check_grants(input string tag, input int which, input logic [NSLOT-1:0] exp[6]);
      logic [NSLOT-1:0] got;
      for (int i = 0; i < 6; i++) begin
         got = '0;
         if (which == 0 && i < g0_q.size()) got = g0_q[i];
         if (which == 1 && i < g1_q.size()) got = g1_q[i];
         check_eq($sformatf("%s[%0d]", tag, i), 64'(got), 64'(exp[i]));
      end
   endtask

   initial begin
      logic [NSLOT-1:0] exp_g[6];
      n_cmp = 0;
      n_mis = 0;

      // Reset state
      clear_inputs();
      rst_n = 1'b0;
      #12;
      check_eq("rst_req_ready", 64'(d0_req_ready), 64'h0);
      check_eq("rst_mst_valid", 64'(d0_mst_valid), 64'h0);
      check_eq("rst_busy", 64'(d0_busy), 64'h0);
      check_eq("rst_owner", 64'(d0_owner), 64'h0);
      check_eq("rst_mst_addr", 64'(d0_mst_addr), 64'h0);
      check_eq("rst_resp_valid", 64'(d0_resp_valid), 64'h0);

      // Single read from slot 2
      do_reset();
      req_valid = 5'b00100;
      req_addr[2*AW +: AW] = 48'h1000;
      #1;
      check_eq("t1_ready_c0", 64'(d0_req_ready), 64'h04);
      check_eq("t1_mstv_c0", 64'(d0_mst_valid), 64'h0);
      tick();
      req_valid = '0;
      mst_req_ready = 1'b1;
      #1;
      check_eq("t1_mstv_c1", 64'(d0_mst_valid), 64'h1);
      check_eq("t1_addr_c1", 64'(d0_mst_addr), 64'h1000);
      check_eq("t1_write_c1", 64'(d0_mst_write), 64'h0);
      check_eq("t1_owner_c1", 64'(d0_owner), 64'h2);
      check_eq("t1_busy_c1", 64'(d0_busy), 64'h1);
      tick();
      mst_req_ready = 1'b0;
      #1;
      check_eq("t1_mstv_c2", 64'(d0_mst_valid), 64'h0);
      check_eq("t1_respv_c2", 64'(d0_resp_valid), 64'h0);
      tick();
      mst_resp_valid = 1'b1;
      mst_resp_rdata = 64'hDEAD;
      #1;
      check_eq("t1_respv_c3", 64'(d0_resp_valid), 64'h04);
      check_eq("t1_rdata_c3", d0_resp_rdata, 64'hDEAD);
      check_eq("t1_err_c3", 64'(d0_resp_err), 64'h0);
      tick();
      mst_resp_valid = 1'b0;
      #1;
      check_eq("t1_busy_c4", 64'(d0_busy), 64'h0);
      check_eq("t1_respv_c4", 64'(d0_resp_valid), 64'h0);

      // All slots valid: round-robin, and ACP priority with guard on the second instance
      do_reset();
      req_valid = 5'b11111;
      mst_req_ready = 1'b1;
      mst_resp_valid = 1'b1;
      collect_grants(6);
      exp_g = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      check_grants("rr_all", 0, exp_g);
      exp_g = '{5'b10000, 5'b10000, 5'b00001, 5'b10000, 5'b10000, 5'b00010};
      check_grants("acp_all", 1, exp_g);

      // ACP and slot 1 only
      do_reset();
      req_valid = 5'b10010;
      mst_req_ready = 1'b1;
      mst_resp_valid = 1'b1;
      collect_grants(6);
      exp_g = '{5'b10000, 5'b10000, 5'b00010, 5'b10000, 5'b10000, 5'b00010};
      check_grants("acp_starve", 1, exp_g);
      exp_g = '{5'b00010, 5'b10000, 5'b00010, 5'b10000, 5'b00010, 5'b10000};
      check_grants("rr_pair", 0, exp_g);

      // Master backpressure on a slot-0 write while slot 3 waits
      do_reset();
      req_valid = 5'b00001;
      req_write = 5'b00001;
      req_addr[0 +: AW] = 48'hABC;
      req_wdata[0 +: DW] = 64'h1122334455667788;
      #1;
      check_eq("bp_ready_c0", 64'(d0_req_ready), 64'h01);
      tick();
      req_valid = 5'b01000;
      req_write = 5'b01000;
      req_addr[0 +: AW] = 48'h0;
      req_wdata[0 +: DW] = 64'h0;
      req_addr[3*AW +: AW] = 48'h3000;
      req_wdata[3*DW +: DW] = 64'hCAFE;
      for (int i = 0; i < 10; i++) begin
         #1;
         check_eq($sformatf("bp_addr_%0d", i), 64'(d0_mst_addr), 64'hABC);
         check_eq($sformatf("bp_wdata_%0d", i), d0_mst_wdata, 64'h1122334455667788);
         check_eq($sformatf("bp_write_%0d", i), 64'(d0_mst_write), 64'h1);
         check_eq($sformatf("bp_mstv_%0d", i), 64'(d0_mst_valid), 64'h1);
         check_eq($sformatf("bp_ready_%0d", i), 64'(d0_req_ready), 64'h0);
         tick();
      end
      mst_req_ready = 1'b1;
      tick();
      mst_req_ready = 1'b0;
      mst_resp_valid = 1'b1;
      mst_resp_rdata = 64'h55;
      #1;
      check_eq("bp_respv", 64'(d0_resp_valid), 64'h01);
      check_eq("bp_rdata", d0_resp_rdata, 64'h55);
      tick();
      mst_resp_valid = 1'b0;
      #1;
      check_eq("bp_next_ready", 64'(d0_req_ready), 64'h08);

      // Error response on the slot-3 write, then a normal read from slot 1
      tick();
      req_valid = '0;
      req_write = '0;
      mst_req_ready = 1'b1;
      #1;
      check_eq("err_write", 64'(d0_mst_write), 64'h1);
      check_eq("err_addr", 64'(d0_mst_addr), 64'h3000);
      check_eq("err_wdata", d0_mst_wdata, 64'hCAFE);
      check_eq("err_owner", 64'(d0_owner), 64'h3);
      tick();
      mst_req_ready = 1'b0;
      mst_resp_valid = 1'b1;
      mst_resp_err = 1'b1;
      #1;
      check_eq("err_respv", 64'(d0_resp_valid), 64'h08);
      check_eq("err_err", 64'(d0_resp_err), 64'h1);
      tick();
      mst_resp_valid = 1'b0;
      mst_resp_err = 1'b0;
      req_valid = 5'b00010;
      req_addr[1*AW +: AW] = 48'h1100;
      #1;
      check_eq("err_next_ready", 64'(d0_req_ready), 64'h02);
      tick();
      req_valid = '0;
      mst_req_ready = 1'b1;
      #1;
      check_eq("err_next_addr", 64'(d0_mst_addr), 64'h1100);
      check_eq("err_next_write", 64'(d0_mst_write), 64'h0);
      tick();
      mst_req_ready = 1'b0;
      mst_resp_valid = 1'b1;
      mst_resp_rdata = 64'h77;
      #1;
      check_eq("err_next_respv", 64'(d0_resp_valid), 64'h02);
      check_eq("err_next_err", 64'(d0_resp_err), 64'h0);
      check_eq("err_next_rdata", d0_resp_rdata, 64'h77);
      tick();
      mst_resp_valid = 1'b0;

      // Reset while waiting in RESP
      do_reset();
      req_valid = 5'b10000;
      req_addr[4*AW +: AW] = 48'h4444;
      #1;
      check_eq("mid_ready", 64'(d0_req_ready), 64'h10);
      tick();
      req_valid = '0;
      mst_req_ready = 1'b1;
      tick();
      mst_req_ready = 1'b0;
      #1;
      check_eq("mid_busy_pre", 64'(d0_busy), 64'h1);
      check_eq("mid_owner_pre", 64'(d0_owner), 64'h4);
      rst_n = 1'b0;
      #1;
      check_eq("mid_busy", 64'(d0_busy), 64'h0);
      check_eq("mid_owner", 64'(d0_owner), 64'h0);
      check_eq("mid_mstv", 64'(d0_mst_valid), 64'h0);
      check_eq("mid_addr", 64'(d0_mst_addr), 64'h0);
      check_eq("mid_respv", 64'(d0_resp_valid), 64'h0);
      mst_resp_valid = 1'b1;
      mst_resp_rdata = 64'hBAD;
      #1;
      check_eq("mid_late_respv", 64'(d0_resp_valid), 64'h0);
      check_eq("mid_late_rdata", d0_resp_rdata, 64'h0);
      tick();
      rst_n = 1'b1;
      #1;
      check_eq("mid_rel_respv", 64'(d0_resp_valid), 64'h0);
      tick();
      check_eq("mid_rel_respv2", 64'(d0_resp_valid), 64'h0);
      check_eq("mid_rel_busy", 64'(d0_busy), 64'h0);
      mst_resp_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
